// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - 52-card deck, deals one card value per request without replacement
module card_dealer #(
   parameter logic [7:0] SEED   = 8'hA5,
   parameter bit         RANDOM = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ,
   input  logic       SHUFFLE,
   output logic [3:0] CARD,
   output logic       VALID,
   output logic       BUSY,
   output logic       EMPTY,
   output logic [5:0] CARDS_LEFT
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DEAL   = 2'd2;

   logic [1:0]  state;
   logic [51:0] used;
   logic [7:0]  lfsr;
   logic [7:0]  lfsr_next;
   logic [5:0]  idx;
   logic [5:0]  cand;
   logic [5:0]  start_idx;

   // Slot i holds rank i mod 13; face cards count as 10.
   function automatic logic [3:0] card_value(input logic [5:0] i);
      logic [5:0] r;
      r = i % 6'd13;
      return (r >= 6'd9) ? 4'd10 : 4'(r + 6'd1);
   endfunction

   assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign cand      = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];
   assign start_idx = RANDOM ? cand : 6'd0;

   assign VALID = (state == S_DEAL);
   assign BUSY  = (state == S_SEARCH) || (state == S_DEAL);
   assign EMPTY = (CARDS_LEFT == 6'd0);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= S_IDLE;
         used       <= '0;
         lfsr       <= SEED;
         idx        <= '0;
         CARD       <= '0;
         CARDS_LEFT <= 6'd52;
      end else begin
         lfsr <= lfsr_next;
         if (SHUFFLE) begin
            used       <= '0;
            CARDS_LEFT <= 6'd52;
            CARD       <= '0;
            state      <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (REQ && !EMPTY) begin
                     idx   <= start_idx;
                     state <= S_SEARCH;
                  end
               end
               S_SEARCH: begin
                  // Linear probe from the start slot; a free slot always exists here.
                  if (!used[idx]) begin
                     used[idx]  <= 1'b1;
                     CARD       <= card_value(idx);
                     CARDS_LEFT <= CARDS_LEFT - 6'd1;
                     state      <= S_DEAL;
                  end else begin
                     idx <= (idx == 6'd51) ? 6'd0 : idx + 6'd1;
                  end
               end
               S_DEAL:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed, table-driven bench for card_dealer
module tb_card_dealer;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       shuf0 = 1'b0, shuf1 = 1'b0;
   logic [3:0] card0, card1;
   logic       valid0, valid1, busy0, busy1, empty0, empty1;
   logic [5:0] cl0, cl1;

   card_dealer #(.SEED(8'hA5), .RANDOM(1'b0)) dut0 (
      .CLK(CLK), .RESET(RESET), .REQ(req0), .SHUFFLE(shuf0),
      .CARD(card0), .VALID(valid0), .BUSY(busy0), .EMPTY(empty0), .CARDS_LEFT(cl0)
   );

   card_dealer #(.SEED(8'hA5), .RANDOM(1'b1)) dut1 (
      .CLK(CLK), .RESET(RESET), .REQ(req1), .SHUFFLE(shuf1),
      .CARD(card1), .VALID(valid1), .BUSY(busy1), .EMPTY(empty1), .CARDS_LEFT(cl1)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] card;
      int         lat;
      logic [5:0] left;
   } vec_t;

   vec_t vecs[13];
   int   passed = 0;
   int   total  = 0;
   int   hist[16];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Called just after a rising edge; returns at the falling edge where VALID is seen.
   task automatic do_req(input bit which, output logic [3:0] c, output int lat, output bit ok);
      c = '0; lat = 0; ok = 1'b0;
      if (which) req1 = 1'b1; else req0 = 1'b1;
      @(posedge CLK); #1;
      req0 = 1'b0; req1 = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         @(negedge CLK);
         if (which ? valid1 : valid0) begin
            lat = n;
            c   = which ? card1 : card0;
            ok  = 1'b1;
            break;
         end
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] c;
      int         lat;
      bit         ok;
      bit         saw;
      int         r;

      vecs[0]  = '{4'd1,  2,  6'd51};
      vecs[1]  = '{4'd2,  3,  6'd50};
      vecs[2]  = '{4'd3,  4,  6'd49};
      vecs[3]  = '{4'd4,  5,  6'd48};
      vecs[4]  = '{4'd5,  6,  6'd47};
      vecs[5]  = '{4'd6,  7,  6'd46};
      vecs[6]  = '{4'd7,  8,  6'd45};
      vecs[7]  = '{4'd8,  9,  6'd44};
      vecs[8]  = '{4'd9,  10, 6'd43};
      vecs[9]  = '{4'd10, 11, 6'd42};
      vecs[10] = '{4'd10, 12, 6'd41};
      vecs[11] = '{4'd10, 13, 6'd40};
      vecs[12] = '{4'd10, 14, 6'd39};

      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_card",  card0, 0);
      check("rst_valid", valid0, 0);
      check("rst_busy",  busy0, 0);
      check("rst_empty", empty0, 0);
      check("rst_left",  cl0, 52);
      check("rst_left_rnd", cl1, 52);
      RESET = 1'b1;
      @(posedge CLK); #1;

      for (int k = 0; k < 13; k++) begin
         do_req(1'b0, c, lat, ok);
         check($sformatf("seq%0d_ok", k + 1), ok, 1);
         check($sformatf("seq%0d_card", k + 1), c, vecs[k].card);
         check($sformatf("seq%0d_lat", k + 1), lat, vecs[k].lat);
         check($sformatf("seq%0d_left", k + 1), cl0, vecs[k].left);
         @(posedge CLK); #1;
      end

      for (int k = 14; k <= 52; k++) begin
         r = (k - 1) % 13;
         do_req(1'b0, c, lat, ok);
         check($sformatf("deck%0d_card", k), c, (r >= 9) ? 10 : r + 1);
         check($sformatf("deck%0d_lat", k), lat, k + 1);
         if (k == 52) begin
            check("last_empty", empty0, 1);
            check("last_left", cl0, 0);
         end
         @(posedge CLK); #1;
      end

      req0 = 1'b1;
      saw  = 1'b0;
      repeat (60) begin
         @(negedge CLK);
         if (valid0 || busy0) saw = 1'b1;
      end
      req0 = 1'b0;
      check("empty_req_ignored", saw, 0);
      @(posedge CLK); #1;

      shuf0 = 1'b1;
      @(posedge CLK); #1;
      shuf0 = 1'b0;
      check("shuf_left",  cl0, 52);
      check("shuf_empty", empty0, 0);
      check("shuf_card",  card0, 0);
      do_req(1'b0, c, lat, ok);
      check("shuf_next_card", c, 1);
      check("shuf_next_lat", lat, 2);
      @(posedge CLK); #1;

      for (int k = 2; k <= 20; k++) begin
         do_req(1'b0, c, lat, ok);
         @(posedge CLK); #1;
      end
      check("twenty_left", cl0, 32);

      req0 = 1'b1;
      @(posedge CLK); #1;
      req0 = 1'b0;
      shuf0 = 1'b1;
      @(posedge CLK); #1;
      shuf0 = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (valid0) saw = 1'b1;
      end
      check("abort_no_valid", saw, 0);
      check("abort_left", cl0, 52);
      check("abort_busy", busy0, 0);
      @(posedge CLK); #1;
      do_req(1'b0, c, lat, ok);
      check("abort_next_card", c, 1);
      check("abort_next_lat", lat, 2);
      @(posedge CLK); #1;

      for (int k = 0; k < 4; k++) begin
         do_req(1'b0, c, lat, ok);
         @(posedge CLK); #1;
      end
      req0 = 1'b1;
      @(posedge CLK); #1;
      req0 = 1'b0;
      @(negedge CLK);
      check("search_busy", busy0, 1);
      @(posedge CLK); #1;
      RESET = 1'b0;
      #1;
      check("midrst_left",  cl0, 52);
      check("midrst_busy",  busy0, 0);
      check("midrst_valid", valid0, 0);
      check("midrst_card",  card0, 0);
      @(posedge CLK); #1;
      RESET = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (valid0) saw = 1'b1;
      end
      check("midrst_no_valid", saw, 0);
      @(posedge CLK); #1;

      for (int v = 0; v < 16; v++) hist[v] = 0;
      for (int k = 1; k <= 52; k++) begin
         do_req(1'b1, c, lat, ok);
         check($sformatf("rnd%0d_ok", k), ok, 1);
         if (ok) hist[c] = hist[c] + 1;
         check($sformatf("rnd%0d_left", k), cl1, 52 - k);
         @(posedge CLK); #1;
         check($sformatf("rnd%0d_valid_width", k), valid1, 0);
      end
      check("rnd_empty", empty1, 1);
      check("rnd_left_zero", cl1, 0);
      for (int v = 1; v <= 10; v++)
         check($sformatf("rnd_hist%0d", v), hist[v], (v == 10) ? 16 : 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Card source for the Black Jack game: holds one 52-card deck and deals one card value per request. Cards are drawn without replacement, in pseudo-random order from an internal LFSR. It sits upstream of the game FSM and drives its CARD input. The player-HIT and dealer-DHIT paths are arbitrated into REQ outside this block. A SHUFFLE input returns every card to the deck.

Parameters:
SEED, 8'hA5, initial LFSR value; must be non-zero.
RANDOM, 1, 1 = LFSR-driven start index; 0 = start index always 0, so cards are dealt in deck order (bench use).

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
REQ  input  1  card request; sampled only in IDLE.
SHUFFLE  input  1  return all 52 cards to the deck; synchronous.
CARD  output  4  value of the last card dealt, 1..10; 0 after reset/shuffle.
VALID  output  1  one-cycle pulse: CARD holds a newly dealt card.
BUSY  output  1  high in SEARCH and DEAL.
EMPTY  output  1  high when all 52 cards are dealt.
CARDS_LEFT  output  6  cards remaining in the deck, 52..0.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; used mask=0; LFSR=SEED.
  - CARD=0, VALID=0, BUSY=0, EMPTY=0, CARDS_LEFT=52.
- Deck: slot index i in 0..51; rank r = i mod 13 (fixed 64-entry lookup); card value = min(r+1, 10).
  - Per deck: 4x each of 1..9, 16x 10.
- Used mask: 52 bits; a bit is set when its slot is dealt.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in every state. Candidate index = lfsr[5:0], minus 52 if >=52.
- States: IDLE, SEARCH, DEAL.
- IDLE:
  - REQ=1 and EMPTY=0: load idx = candidate (0 if RANDOM=0), go to SEARCH.
  - REQ=1 and EMPTY=1: ignored; no VALID, stay in IDLE.
- SEARCH:
  - Each cycle test used[idx].
  - If clear: set used[idx], CARD <= value(idx), CARDS_LEFT decrements by 1, go to DEAL.
  - If set: idx <= (idx==51) ? 0 : idx+1; stay in SEARCH.
  - Termination is guaranteed because EMPTY=0 on entry; at most 52 SEARCH cycles.
- DEAL: VALID=1 for exactly this cycle, then go to IDLE. EMPTY asserts in this same cycle if CARDS_LEFT reached 0.
- Latency, REQ sampled to VALID high: 2 + (number of used slots skipped) cycles. Minimum 2, maximum 53.
- REQ is level-sampled in IDLE only; REQ held high gives back-to-back deals, one every >=3 cycles. REQ during SEARCH/DEAL is ignored and not queued.
- CARD holds its value after VALID drops, until the next deal, shuffle or reset.
- SHUFFLE=1 (any state) has priority over REQ and over an in-progress search:
  - Next cycle: used mask=0, CARDS_LEFT=52, EMPTY=0, CARD=0, state=IDLE.
  - No VALID is produced for an aborted request; the LFSR is not reseeded.
- SHUFFLE in the DEAL cycle: VALID still pulses that cycle; the shuffle takes effect on the following edge.
- Reset mid-operation behaves exactly as reset; no VALID is produced afterwards.

Test Plan:
- RANDOM=0, 13 REQ pulses after reset -> CARD sequence 1,2,3,4,5,6,7,8,9,10,10,10,10. CARDS_LEFT 52->39. Latency of the k-th deal (k from 1) = k+1 cycles.
- RANDOM=0, 52 requests -> 52nd VALID coincides with EMPTY=1 and CARDS_LEFT=0. 53rd REQ -> no VALID within 60 cycles; BUSY stays 0.
- RANDOM=1, SEED=8'hA5, 52 requests -> all 52 slots dealt exactly once. Value histogram: 4 each of 1..9, 16 of 10. Every VALID is exactly 1 cycle wide.
- After EMPTY, pulse SHUFFLE -> next cycle CARDS_LEFT=52, EMPTY=0, CARD=0. Next REQ (RANDOM=0) -> CARD=1.
- RANDOM=0, 20 cards dealt, REQ then SHUFFLE 1 cycle later (mid-SEARCH) -> no VALID, CARDS_LEFT=52. Next REQ -> CARD=1 after 2 cycles.
- Drive RESET low during SEARCH -> outputs immediately at reset values (CARDS_LEFT=52, BUSY=0). No VALID after release until a new REQ.
